// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: fetches a word at PC, hands it to decode,
// waits a fixed execute time, then advances or branches the PC.
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          EXEC_CYCLES = 4
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        EXEC,
    output logic [15:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] COMMAND,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    input  logic        PC_load,
    input  logic [15:0] branch_target,
    output logic [15:0] PC,
    output logic        halted
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        HALT
    } state_t;

    localparam logic [3:0] COUNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_exec_q;
    logic [15:0] r_pc;
    logic [15:0] r_command;
    logic        r_cmd_valid;
    logic [3:0]  r_count;
    logic        r_stop_req;
    logic        r_br_pend;
    logic [15:0] r_br_tgt;

    logic        w_exec_pulse;
    logic        w_is_hlt;
    logic        w_boundary;
    logic        w_stop;

    assign w_exec_pulse = EXEC & ~r_exec_q;
    assign w_is_hlt     = (r_command[15:14] == 2'b11) && (r_command[7:4] == 4'b1111);
    assign w_boundary   = (r_state == WAIT) && (r_count == 4'd0);
    // A run/stop press landing on the boundary cycle itself still stops here.
    assign w_stop       = r_stop_req | w_exec_pulse;

    assign mem_req   = (r_state == FETCH);
    assign mem_addr  = r_pc;
    assign PC        = r_pc;
    assign COMMAND   = r_command;
    assign cmd_valid = r_cmd_valid;
    assign halted    = (r_state == HALT);

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_exec_pulse) w_state_nxt = FETCH;
            end
            FETCH: begin
                if (mem_ack) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                if (cmd_ready) w_state_nxt = w_is_hlt ? HALT : WAIT;
            end
            WAIT: begin
                if (r_count == 4'd0) w_state_nxt = w_stop ? IDLE : FETCH;
            end
            HALT: begin
                if (w_exec_pulse) w_state_nxt = FETCH;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_exec_q    <= 1'b0;
            r_pc        <= RESET_PC;
            r_command   <= 16'h0000;
            r_cmd_valid <= 1'b0;
            r_count     <= 4'd0;
            r_stop_req  <= 1'b0;
            r_br_pend   <= 1'b0;
            r_br_tgt    <= 16'h0000;
        end else begin
            r_exec_q <= EXEC;

            if ((r_state == FETCH) || (r_state == ISSUE) || (r_state == WAIT)) begin
                if (w_boundary) begin
                    r_stop_req <= 1'b0;
                end else if (w_exec_pulse) begin
                    r_stop_req <= 1'b1;
                end
            end

            case (r_state)
                FETCH: begin
                    if (mem_ack) begin
                        r_command   <= mem_rdata;
                        r_cmd_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        if (!w_is_hlt) r_count <= COUNT_LOAD;
                    end
                end
                WAIT: begin
                    if (PC_load) begin
                        r_br_tgt  <= branch_target;
                        r_br_pend <= 1'b1;
                    end
                    // Boundary: a same-cycle PC_load beats any earlier latched target.
                    if (r_count == 4'd0) begin
                        r_br_pend <= 1'b0;
                        if (PC_load) begin
                            r_pc <= branch_target;
                        end else if (r_br_pend) begin
                            r_pc <= r_br_tgt;
                        end else begin
                            r_pc <= r_pc + 16'd1;
                        end
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                HALT: begin
                    if (w_exec_pulse) r_pc <= r_pc + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
